pattern_sequencer: RTL and testbench
====================================

// Module: pattern_sequencer
// PURPOSE
//  Frame-synchronous controller for the VGA test-pattern generator.
//  Selects which pattern is shown, and auto-advances every FRAMES_PER_PATTERN frames.
//  Supports manual "next" and "hold" keys, inserts black frames between patterns,
//  and drives a horizontal scroll offset. Sits between the VGA timing block
//  (start_of_frame) and the pattern datapath (pattern_sel/x_offset/blank_en).
// PARAMETERS
//  NUM_PATTERNS        4       number of selectable patterns, pattern_sel wraps at NUM_PATTERNS-1
//  FRAMES_PER_PATTERN  120     frames shown per pattern before auto-advance (>=1)
//  BLANK_FRAMES        2       black frames inserted on each change; 0 = no blanking
//  DEBOUNCE_CYCLES     250000  stable clocks required to accept a key level (10 ms @ 25 MHz)
//  SCROLL_STEP         1       x_offset increment per frame in RUN (0..639)
// PORTS
//  clk_25           in   1   25 MHz pixel clock, single clock domain
//  resetN           in   1   asynchronous reset, active low
//  start_of_frame   in   1   1-cycle pulse at pxl_x=0, pxl_y=0 (sof)
//  auto_en          in   1   1 = auto-advance enabled (slide switch, quasi-static)
//  key_nextN        in   1   raw push-button, active low, asynchronous
//  key_holdN        in   1   raw push-button, active low, asynchronous
//  pattern_sel      out  3   current pattern index, 0..NUM_PATTERNS-1
//  x_offset         out  10  horizontal scroll offset, 0..639
//  blank_en         out  1   1 = datapath must output black
//  pattern_changed  out  1   1-cycle pulse when pattern_sel updates
// BEHAVIOUR
//  - Reset (async): state RUN, pattern_sel=0, x_offset=0, blank_en=0, pattern_changed=0,
//    frame_cnt=0, hold_flag=0, next_pending=0. Reset mid-BLANK aborts immediately.
//  - All outputs registered; every update takes effect the cycle after the sof pulse.
//    Between sofs, outputs are constant (no mid-frame tearing).
//  - Keys: each key is debounced. A debounced 1->0 transition produces a 1-cycle press pulse.
//    A next press sets next_pending. A hold press toggles hold_req. Both are consumed at the next sof.
//  - States: RUN, HOLD, BLANK. Actions on each sof:
//    RUN: if next_pending, or (auto_en and frame_cnt==FRAMES_PER_PATTERN-1), then advance.
//      Otherwise frame_cnt++ and x_offset+=SCROLL_STEP.
//    HOLD: frame_cnt and x_offset are frozen and auto-advance is disabled.
//      next_pending still causes an advance.
//    Hold toggle: hold_flag^=hold_req at the sof. If no advance occurs, the state
//      becomes HOLD when hold_flag=1, otherwise RUN.
//    Advance with BLANK_FRAMES>0: go to BLANK, blank_en=1, blank_cnt=0.
//      In BLANK, each sof increments blank_cnt.
//      At the sof where blank_cnt==BLANK_FRAMES-1: pattern_sel++, blank_en=0,
//        pattern_changed pulse, then return to HOLD if hold_flag else RUN.
//    Advance with BLANK_FRAMES==0: pattern_sel++ and pattern_changed pulse at the same sof.
//    Every advance clears frame_cnt, x_offset and next_pending.
//  - Wrap rules:
//    pattern_sel: NUM_PATTERNS-1 -> 0.
//    x_offset: if x_offset+SCROLL_STEP>=640, subtract 640 (10-bit, never exceeds 639).
//  - Simultaneous events:
//    next_pending and auto expiry at the same sof cause exactly one advance.
//    hold and next at the same sof: both take effect (advance, then land in the toggled state).
//    Next presses during BLANK are dropped. Hold presses during BLANK toggle hold_flag, applied on exit.
//    A second next press before the sof does not queue a second advance.
//  - frame_cnt width is $clog2(FRAMES_PER_PATTERN).
//  - start_of_frame asserted on consecutive cycles counts as separate frames (no filtering).
// STRUCTURE
//  - Package pattern_pkg:
//    seq_state_t enum {RUN, HOLD, BLANK};
//    H_ACTIVE=640, V_ACTIVE=480;
//    PAT_W=3 (pattern index width).
//  - Sub-module key_debounce (one instance per key):
//    2-FF synchronizer; level counter requiring DEBOUNCE_CYCLES consecutive stable samples;
//    outputs press_pulse on the accepted 1->0 transition. Reset level = released (1).
//  - Top: one FSM, frame/blank counters, scroll accumulator, output registers.
// TESTING  (bench params: NUM_PATTERNS=4, FRAMES_PER_PATTERN=3, BLANK_FRAMES=1,
//           DEBOUNCE_CYCLES=4, SCROLL_STEP=100; sof every 50 clks)
//  1. Reset, auto_en=1, 3 sofs -> blank_en=1 for 1 frame.
//     Next sof -> pattern_sel=1, blank_en=0, pattern_changed high exactly 1 cycle.
//  2. auto_en=1 for 4 advances -> pattern_sel sequence 1,2,3,0.
//  3. key_nextN low 2 clks (bounce) -> no advance.
//     key_nextN low 10 clks -> advance only at the following sof, never mid-frame.
//  4. Press hold -> HOLD from next sof; 10 sofs -> pattern_sel/x_offset unchanged.
//     Press next -> BLANK then pattern_sel+1, returns to HOLD.
//  5. auto_en=0, 7 sofs in RUN -> x_offset 100..600, then 60 (700-640 wrap).
//  6. resetN low mid-BLANK (async, no clock edge) -> pattern_sel=0, blank_en=0 immediately.
//     After release, the state is RUN.

Source files
------------

// File: rtl/pattern_pkg.sv
// rtl/pattern_pkg.sv - shared types, screen constants and scroll helper for the pattern sequencer
package pattern_pkg;

  typedef enum logic [1:0] {
    RUN   = 2'd0,
    HOLD  = 2'd1,
    BLANK = 2'd2
  } seq_state_t;

  localparam int H_ACTIVE = 640;
  localparam int V_ACTIVE = 480;
  localparam int PAT_W    = 3;

  // Wraps the scroll position back into the visible width; step is always < H_ACTIVE.
  function automatic logic [9:0] scroll_add(input logic [9:0] x, input logic [9:0] step);
    logic [10:0] sum;
    sum = {1'b0, x} + {1'b0, step};
    if (sum >= 11'(H_ACTIVE)) begin
      sum = sum - 11'(H_ACTIVE);
    end
    return sum[9:0];
  endfunction

endpackage

// File: rtl/pattern_sequencer_debounce.sv
// rtl/pattern_sequencer_debounce.sv - key synchronizer/debouncer emitting a pulse on each accepted press
module key_debounce #(
  parameter int DEBOUNCE_CYCLES = 250000
) (
  input  logic clk,
  input  logic rst_n,
  input  logic key_n,
  output logic press_pulse
);

  localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

  logic [1:0]    sync_q;
  logic          level_q;
  logic [CW-1:0] cnt_q;
  logic          press_q;

  // A new level is accepted only after DEBOUNCE_CYCLES consecutive samples differ from the held one.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q  <= 2'b11;
      level_q <= 1'b1;
      cnt_q   <= '0;
      press_q <= 1'b0;
    end else begin
      sync_q  <= {sync_q[0], key_n};
      press_q <= 1'b0;
      if (sync_q[1] != level_q) begin
        if (cnt_q == CNT_LAST) begin
          level_q <= sync_q[1];
          cnt_q   <= '0;
          press_q <= level_q & ~sync_q[1];
        end else begin
          cnt_q <= cnt_q + 1'b1;
        end
      end else begin
        cnt_q <= '0;
      end
    end
  end

  assign press_pulse = press_q;

endmodule

// File: rtl/pattern_sequencer.sv
// rtl/pattern_sequencer.sv - frame-synchronous pattern selector with auto-advance, hold, blanking and scroll
module pattern_sequencer
  import pattern_pkg::*;
#(
  parameter int NUM_PATTERNS       = 4,
  parameter int FRAMES_PER_PATTERN = 120,
  parameter int BLANK_FRAMES       = 2,
  parameter int DEBOUNCE_CYCLES    = 250000,
  parameter int SCROLL_STEP        = 1
) (
  input  logic             clk_25,
  input  logic             resetN,
  input  logic             start_of_frame,
  input  logic             auto_en,
  input  logic             key_nextN,
  input  logic             key_holdN,
  output logic [PAT_W-1:0] pattern_sel,
  output logic [9:0]       x_offset,
  output logic             blank_en,
  output logic             pattern_changed
);

  localparam int FCW = (FRAMES_PER_PATTERN > 1) ? $clog2(FRAMES_PER_PATTERN) : 1;
  localparam int BCW = (BLANK_FRAMES > 1) ? $clog2(BLANK_FRAMES) : 1;
  localparam logic [FCW-1:0]   FRAME_LAST = FCW'(FRAMES_PER_PATTERN - 1);
  localparam logic [BCW-1:0]   BLANK_LAST = BCW'((BLANK_FRAMES > 0) ? BLANK_FRAMES - 1 : 0);
  localparam logic [PAT_W-1:0] PAT_LAST   = PAT_W'(NUM_PATTERNS - 1);
  localparam logic [9:0]       STEP       = 10'(SCROLL_STEP);

  logic next_press, hold_press;

  key_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_next_db (
    .clk         (clk_25),
    .rst_n       (resetN),
    .key_n       (key_nextN),
    .press_pulse (next_press)
  );

  key_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_hold_db (
    .clk         (clk_25),
    .rst_n       (resetN),
    .key_n       (key_holdN),
    .press_pulse (hold_press)
  );

  seq_state_t       state_q, state_d;
  logic [FCW-1:0]   frame_cnt_q, frame_cnt_d;
  logic [BCW-1:0]   blank_cnt_q, blank_cnt_d;
  logic             hold_flag_q, hold_flag_d;
  logic             hold_req_q, hold_req_d;
  logic             next_pending_q, next_pending_d;
  logic [PAT_W-1:0] pattern_sel_q, pattern_sel_d;
  logic [9:0]       x_offset_q, x_offset_d;
  logic             blank_en_q, blank_en_d;
  logic             changed_q, changed_d;

  logic             next_eff, hold_eff, hold_new, advance;
  seq_state_t       rest_state;
  logic [PAT_W-1:0] pattern_inc;

  always_ff @(posedge clk_25 or negedge resetN) begin
    if (!resetN) begin
      state_q        <= RUN;
      frame_cnt_q    <= '0;
      blank_cnt_q    <= '0;
      hold_flag_q    <= 1'b0;
      hold_req_q     <= 1'b0;
      next_pending_q <= 1'b0;
      pattern_sel_q  <= '0;
      x_offset_q     <= '0;
      blank_en_q     <= 1'b0;
      changed_q      <= 1'b0;
    end else begin
      state_q        <= state_d;
      frame_cnt_q    <= frame_cnt_d;
      blank_cnt_q    <= blank_cnt_d;
      hold_flag_q    <= hold_flag_d;
      hold_req_q     <= hold_req_d;
      next_pending_q <= next_pending_d;
      pattern_sel_q  <= pattern_sel_d;
      x_offset_q     <= x_offset_d;
      blank_en_q     <= blank_en_d;
      changed_q      <= changed_d;
    end
  end

  always_comb begin
    state_d        = state_q;
    frame_cnt_d    = frame_cnt_q;
    blank_cnt_d    = blank_cnt_q;
    hold_flag_d    = hold_flag_q;
    pattern_sel_d  = pattern_sel_q;
    x_offset_d     = x_offset_q;
    blank_en_d     = blank_en_q;
    changed_d      = 1'b0;
    advance        = 1'b0;

    // A press landing on the sof cycle itself is folded into that frame's decision.
    next_eff       = next_pending_q | (next_press & (state_q != BLANK));
    hold_eff       = hold_req_q ^ hold_press;
    hold_new       = hold_flag_q ^ hold_eff;
    rest_state     = hold_new ? HOLD : RUN;
    pattern_inc    = (pattern_sel_q == PAT_LAST) ? '0 : pattern_sel_q + 1'b1;
    next_pending_d = next_eff;
    hold_req_d     = hold_eff;

    if (start_of_frame) begin
      next_pending_d = 1'b0;
      hold_req_d     = 1'b0;
      hold_flag_d    = hold_new;
      case (state_q)
        RUN, HOLD: begin
          advance = next_eff || (state_q == RUN && auto_en && frame_cnt_q == FRAME_LAST);
          if (advance) begin
            frame_cnt_d = '0;
            x_offset_d  = '0;
            if (BLANK_FRAMES > 0) begin
              state_d     = BLANK;
              blank_en_d  = 1'b1;
              blank_cnt_d = '0;
            end else begin
              pattern_sel_d = pattern_inc;
              changed_d     = 1'b1;
              state_d       = rest_state;
            end
          end else begin
            if (state_q == RUN) begin
              frame_cnt_d = (frame_cnt_q == FRAME_LAST) ? '0 : frame_cnt_q + 1'b1;
              x_offset_d  = scroll_add(x_offset_q, STEP);
            end
            state_d = rest_state;
          end
        end
        BLANK: begin
          if (blank_cnt_q == BLANK_LAST) begin
            pattern_sel_d = pattern_inc;
            blank_en_d    = 1'b0;
            changed_d     = 1'b1;
            state_d       = rest_state;
          end else begin
            blank_cnt_d = blank_cnt_q + 1'b1;
          end
        end
        default: state_d = RUN;
      endcase
    end
  end

  assign pattern_sel     = pattern_sel_q;
  assign x_offset        = x_offset_q;
  assign blank_en        = blank_en_q;
  assign pattern_changed = changed_q;

endmodule

// File: tb/tb_pattern_sequencer.sv
// tb/tb_pattern_sequencer.sv - directed self-checking bench for pattern_sequencer
module tb_pattern_sequencer;

  logic       clk_25;
  logic       resetN;
  logic       start_of_frame;
  logic       auto_en;
  logic       key_nextN;
  logic       key_holdN;
  logic [2:0] pattern_sel;
  logic [9:0] x_offset;
  logic       blank_en;
  logic       pattern_changed;

  int n_checks = 0;
  int n_fail   = 0;
  logic pc_first, pc_second;
  logic [2:0] sel_after_sof;

  pattern_sequencer #(
    .NUM_PATTERNS       (4),
    .FRAMES_PER_PATTERN (3),
    .BLANK_FRAMES       (1),
    .DEBOUNCE_CYCLES    (4),
    .SCROLL_STEP        (100)
  ) dut (
    .clk_25          (clk_25),
    .resetN          (resetN),
    .start_of_frame  (start_of_frame),
    .auto_en         (auto_en),
    .key_nextN       (key_nextN),
    .key_holdN       (key_holdN),
    .pattern_sel     (pattern_sel),
    .x_offset        (x_offset),
    .blank_en        (blank_en),
    .pattern_changed (pattern_changed)
  );

  initial clk_25 = 1'b0;
  always #5 clk_25 = ~clk_25;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // One 50-clock frame: sof on the first cycle, optional key lows, padding to the end.
  task automatic frame(input int next_low, input int hold_low);
    int used;
    used = 0;
    @(negedge clk_25);
    start_of_frame = 1'b1;
    @(negedge clk_25);
    start_of_frame = 1'b0;
    pc_first      = pattern_changed;
    sel_after_sof = pattern_sel;
    @(negedge clk_25);
    pc_second = pattern_changed;
    used = 1;
    if (next_low > 0) begin
      key_nextN = 1'b0;
      repeat (next_low) @(negedge clk_25);
      key_nextN = 1'b1;
      used += next_low;
    end
    if (hold_low > 0) begin
      key_holdN = 1'b0;
      repeat (hold_low) @(negedge clk_25);
      key_holdN = 1'b1;
      used += hold_low;
    end
    repeat (48 - used) @(negedge clk_25);
  endtask

  initial begin
    resetN         = 1'b0;
    start_of_frame = 1'b0;
    auto_en        = 1'b1;
    key_nextN      = 1'b1;
    key_holdN      = 1'b1;
    repeat (3) @(negedge clk_25);
    check("reset_sel", pattern_sel, 0);
    check("reset_x", x_offset, 0);
    check("reset_blank", blank_en, 0);
    check("reset_changed", pattern_changed, 0);
    resetN = 1'b1;

    // auto-advance after 3 frames, one black frame
    frame(0, 0);
    frame(0, 0);
    check("t1_x_scroll", x_offset, 200);
    frame(0, 0);
    check("t1_blank_on", blank_en, 1);
    check("t1_sel_in_blank", pattern_sel, 0);
    check("t1_x_cleared", x_offset, 0);
    frame(0, 0);
    check("t1_sel", pattern_sel, 1);
    check("t1_blank_off", blank_en, 0);
    check("t1_changed_pulse", pc_first, 1);
    check("t1_changed_one_cycle", pc_second, 0);

    for (int k = 0; k < 3; k++) begin
      repeat (4) frame(0, 0);
      check("t2_auto_seq", pattern_sel, (k + 2) % 4);
    end

    // debounced next key
    auto_en = 1'b0;
    frame(2, 0);
    check("t3_bounce_sel", pattern_sel, 0);
    check("t3_bounce_blank", blank_en, 0);
    frame(10, 0);
    check("t3_no_midframe_sel", pattern_sel, 0);
    check("t3_no_midframe_blank", blank_en, 0);
    check("t3_x", x_offset, 200);
    frame(0, 0);
    check("t3_blank", blank_en, 1);
    frame(0, 0);
    check("t3_sel", pattern_sel, 1);

    // hold freezes scroll and auto-advance; next still advances and lands back in hold
    frame(0, 10);
    check("t4_x_before_hold", x_offset, 100);
    frame(0, 0);
    check("t4_x_enter_hold", x_offset, 200);
    auto_en = 1'b1;
    repeat (10) frame(0, 0);
    check("t4_hold_sel", pattern_sel, 1);
    check("t4_hold_x", x_offset, 200);
    check("t4_hold_blank", blank_en, 0);
    frame(10, 0);
    frame(0, 0);
    check("t4_blank", blank_en, 1);
    frame(0, 0);
    check("t4_sel", pattern_sel, 2);
    check("t4_blank_off", blank_en, 0);
    repeat (5) frame(0, 0);
    check("t4_back_in_hold_sel", pattern_sel, 2);
    check("t4_back_in_hold_x", x_offset, 0);

    // leave hold, then scroll with wrap past 640
    auto_en = 1'b0;
    frame(0, 10);
    frame(0, 0);
    check("t5_x_start", x_offset, 0);
    for (int k = 1; k <= 7; k++) begin
      frame(0, 0);
      check("t5_x", x_offset, (k == 7) ? 60 : 100 * k);
    end
    check("t5_sel", pattern_sel, 2);

    // asynchronous reset in the middle of a black frame
    frame(10, 0);
    frame(0, 0);
    check("t6_blank_before_reset", blank_en, 1);
    @(negedge clk_25);
    #2 resetN = 1'b0;
    #1;
    check("t6_async_sel", pattern_sel, 0);
    check("t6_async_blank", blank_en, 0);
    check("t6_async_x", x_offset, 0);
    @(negedge clk_25);
    resetN = 1'b1;
    frame(0, 0);
    check("t6_run_scroll", x_offset, 100);
    check("t6_run_sel", pattern_sel, 0);
    check("t6_run_blank", blank_en, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
